// File: rtl/fetch_controller.sv
// Instruction fetch/sequence controller: fetches a word at the current PC, decodes
// a halt opcode, hands other instructions to the execute unit, then pulses the PC update.
module fetch_controller #(
  parameter logic [7:0]  MEM_TIMEOUT = 8'd255,
  parameter logic [15:0] HALT_OPCODE = 16'hF000
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        Run,
  input  logic        MemReady,
  input  logic [15:0] MemData,
  input  logic        ExecDone,
  input  logic        BranchTaken,
  input  logic [15:0] BranchTarget,
  output logic        MemRead,
  output logic        PcIncrement,
  output logic [7:0]  PcStep,
  output logic        PcWriteEnable,
  output logic [15:0] PcLoadValue,
  output logic [15:0] IR,
  output logic        ExecStart,
  output logic        Halted,
  output logic        Fault,
  output logic [2:0]  State
);

  // Handshakes: MemReady is a one-cycle valid that is only honoured while the
  // controller is in WAIT; ExecDone is a one-cycle valid honoured only in EXEC.
  // Neither has a back-pressure ready; the controller always accepts them there.
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_WAIT   = 3'd2,
    S_DECODE = 3'd3,
    S_EXEC   = 3'd4,
    S_HALTED = 3'd5,
    S_FAULT  = 3'd6
  } state_e;

  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [15:0] ir_q, ir_d;
  logic [15:0] pcl_q, pcl_d;
  logic        inc_q, inc_d;
  logic        we_q, we_d;

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 8'd0;
      ir_q    <= 16'h0000;
      pcl_q   <= 16'h0000;
      inc_q   <= 1'b0;
      we_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ir_q    <= ir_d;
      pcl_q   <= pcl_d;
      inc_q   <= inc_d;
      we_q    <= we_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ir_d    = ir_q;
    pcl_d   = pcl_q;
    inc_d   = 1'b0;
    we_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (Run) state_d = S_FETCH;
      end
      S_FETCH: begin
        cnt_d   = 8'd0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // Data arriving on the last permitted cycle still wins over the timeout.
        if (MemReady) begin
          ir_d    = MemData;
          state_d = S_DECODE;
        end else if (cnt_q == MEM_TIMEOUT) begin
          state_d = S_FAULT;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_DECODE: begin
        state_d = (ir_q == HALT_OPCODE) ? S_HALTED : S_EXEC;
      end
      S_EXEC: begin
        if (ExecDone) begin
          if (BranchTaken) begin
            we_d  = 1'b1;
            pcl_d = BranchTarget;
          end else begin
            inc_d = 1'b1;
          end
          state_d = Run ? S_FETCH : S_IDLE;
        end
      end
      S_HALTED: state_d = S_HALTED;
      S_FAULT:  state_d = S_FAULT;
      default:  state_d = S_IDLE;
    endcase
  end

  assign MemRead       = (state_q == S_FETCH) || (state_q == S_WAIT);
  assign ExecStart     = (state_q == S_DECODE) && (ir_q != HALT_OPCODE);
  assign Halted        = (state_q == S_HALTED);
  assign Fault         = (state_q == S_FAULT);
  assign PcIncrement   = inc_q;
  assign PcWriteEnable = we_q;
  assign PcLoadValue   = pcl_q;
  assign PcStep        = 8'd1;
  assign IR            = ir_q;
  assign State         = state_q;

endmodule

// File: tb/tb_fetch_controller.sv
// Scenario bench for fetch_controller: fetched words and branch targets go into
// expected queues when driven and are compared when the DUT presents them.
module tb_fetch_controller;

  logic        Clock = 1'b0;
  logic        Reset = 1'b0;
  logic        Run = 1'b0;
  logic        MemReady = 1'b0;
  logic [15:0] MemData = 16'h0000;
  logic        ExecDone = 1'b0;
  logic        BranchTaken = 1'b0;
  logic [15:0] BranchTarget = 16'h0000;
  logic        MemRead, PcIncrement, PcWriteEnable, ExecStart, Halted, Fault;
  logic [7:0]  PcStep;
  logic [15:0] PcLoadValue, IR;
  logic [2:0]  State;

  fetch_controller dut (
    .Clock(Clock), .Reset(Reset), .Run(Run), .MemReady(MemReady), .MemData(MemData),
    .ExecDone(ExecDone), .BranchTaken(BranchTaken), .BranchTarget(BranchTarget),
    .MemRead(MemRead), .PcIncrement(PcIncrement), .PcStep(PcStep),
    .PcWriteEnable(PcWriteEnable), .PcLoadValue(PcLoadValue), .IR(IR),
    .ExecStart(ExecStart), .Halted(Halted), .Fault(Fault), .State(State)
  );

  // ---------------- clock / reset ----------------
  always #5 Clock = ~Clock;

  int n_cmp = 0;
  int n_err = 0;
  logic [15:0] exp_q[$];
  logic [15:0] pcl_q[$];

  // Pulse counters sampled shortly after each rising edge.
  int n_es = 0, n_inc = 0, n_we = 0, n_both = 0;
  always @(posedge Clock) begin
    #2;
    if (ExecStart === 1'b1) n_es++;
    if (PcIncrement === 1'b1) n_inc++;
    if (PcWriteEnable === 1'b1) n_we++;
    if (PcIncrement === 1'b1 && PcWriteEnable === 1'b1) n_both++;
  end

  task automatic tick();
    @(posedge Clock);
    @(negedge Clock);
  endtask

  task automatic do_reset();
    Reset = 1'b0; Run = 1'b0; MemReady = 1'b0; MemData = 16'h0000;
    ExecDone = 1'b0; BranchTaken = 1'b0; BranchTarget = 16'h0000;
    exp_q.delete();
    pcl_q.delete();
    tick();
    tick();
    Reset = 1'b1;
  endtask

  // ---------------- driver tasks ----------------
  task automatic start_run();
    Run = 1'b1;
    tick();
  endtask

  // From FETCH: enter WAIT, hold off dly cycles, then present the word. Ends in DECODE.
  task automatic feed_mem(input logic [15:0] data, input int dly);
    tick();
    repeat (dly) tick();
    MemReady = 1'b1;
    MemData  = data;
    exp_q.push_back(data);
    tick();
    MemReady = 1'b0;
    MemData  = 16'h0000;
  endtask

  // From DECODE: enter EXEC, wait dly cycles, then signal completion. Ends on the pulse cycle.
  task automatic finish_exec(input int dly, input logic taken, input logic [15:0] tgt);
    tick();
    repeat (dly) tick();
    ExecDone     = 1'b1;
    BranchTaken  = taken;
    BranchTarget = tgt;
    if (taken) pcl_q.push_back(tgt);
    tick();
    ExecDone    = 1'b0;
    BranchTaken = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    Reset = 1'b0; Run = 1'b1; MemReady = 1'b1; ExecDone = 1'b1;
    tick();
    n_cmp++; if (State !== 3'd0) begin n_err++; $display("FAIL rst_state: got %0d want 0", State); end
    n_cmp++; if (IR !== 16'h0000) begin n_err++; $display("FAIL rst_ir: got %0h want 0", IR); end
    n_cmp++; if (PcLoadValue !== 16'h0000) begin n_err++; $display("FAIL rst_pcl: got %0h want 0", PcLoadValue); end
    n_cmp++; if ({MemRead, PcIncrement, PcWriteEnable, ExecStart, Halted, Fault} !== 6'b0) begin
      n_err++; $display("FAIL rst_bits: got %b want 000000", {MemRead, PcIncrement, PcWriteEnable, ExecStart, Halted, Fault}); end
    n_cmp++; if (PcStep !== 8'd1) begin n_err++; $display("FAIL rst_step: got %0d want 1", PcStep); end
    Run = 1'b0; MemReady = 1'b0; ExecDone = 1'b0;
    Reset = 1'b1;
    repeat (3) tick();
    n_cmp++; if (State !== 3'd0) begin n_err++; $display("FAIL idle_hold: got %0d want 0", State); end
    Run = 1'b1;
    tick();
    n_cmp++; if (State !== 3'd1 || MemRead !== 1'b1) begin
      n_err++; $display("FAIL first_fetch: got state %0d rd %b want 1 1", State, MemRead); end
    Run = 1'b0;
  endtask

  task automatic test_no_branch();
    int es0, inc0, we0;
    logic [15:0] exp;
    do_reset();
    es0 = n_es; inc0 = n_inc; we0 = n_we;
    start_run();
    feed_mem(16'h1234, 0);
    exp = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hxxxx;
    n_cmp++; if (State !== 3'd3 || ExecStart !== 1'b1) begin
      n_err++; $display("FAIL nb_decode: got state %0d es %b want 3 1", State, ExecStart); end
    n_cmp++; if (IR !== exp) begin n_err++; $display("FAIL nb_ir: got %0h want %0h", IR, exp); end
    finish_exec(1, 1'b0, 16'h0000);
    n_cmp++; if (State !== 3'd1 || PcIncrement !== 1'b1 || PcWriteEnable !== 1'b0) begin
      n_err++; $display("FAIL nb_pulse: got state %0d inc %b we %b want 1 1 0", State, PcIncrement, PcWriteEnable); end
    tick();
    n_cmp++; if (PcIncrement !== 1'b0) begin n_err++; $display("FAIL nb_pulse_width: got %b want 0", PcIncrement); end
    n_cmp++; if (n_es - es0 != 1 || n_inc - inc0 != 1 || n_we - we0 != 0) begin
      n_err++; $display("FAIL nb_counts: got es %0d inc %0d we %0d want 1 1 0", n_es - es0, n_inc - inc0, n_we - we0); end
  endtask

  task automatic test_branch();
    int inc0, we0;
    logic [15:0] exp;
    do_reset();
    inc0 = n_inc; we0 = n_we;
    start_run();
    feed_mem(16'h2345, 0);
    exp = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hxxxx;
    n_cmp++; if (IR !== exp) begin n_err++; $display("FAIL br_ir: got %0h want %0h", IR, exp); end
    finish_exec(1, 1'b1, 16'h00A0);
    exp = (pcl_q.size() > 0) ? pcl_q.pop_front() : 16'hxxxx;
    n_cmp++; if (PcWriteEnable !== 1'b1 || PcIncrement !== 1'b0 || State !== 3'd1) begin
      n_err++; $display("FAIL br_pulse: got we %b inc %b state %0d want 1 0 1", PcWriteEnable, PcIncrement, State); end
    n_cmp++; if (PcLoadValue !== exp) begin n_err++; $display("FAIL br_target: got %0h want %0h", PcLoadValue, exp); end
    tick();
    n_cmp++; if (PcWriteEnable !== 1'b0 || PcLoadValue !== 16'h00A0) begin
      n_err++; $display("FAIL br_after: got we %b pcl %0h want 0 a0", PcWriteEnable, PcLoadValue); end
    n_cmp++; if (n_we - we0 != 1 || n_inc - inc0 != 0) begin
      n_err++; $display("FAIL br_counts: got we %0d inc %0d want 1 0", n_we - we0, n_inc - inc0); end
  endtask

  task automatic test_halt();
    int es0, inc0, we0;
    logic [15:0] exp;
    do_reset();
    es0 = n_es; inc0 = n_inc; we0 = n_we;
    start_run();
    feed_mem(16'hF000, 0);
    exp = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hxxxx;
    n_cmp++; if (IR !== exp || ExecStart !== 1'b0 || State !== 3'd3) begin
      n_err++; $display("FAIL halt_decode: got ir %0h es %b state %0d want %0h 0 3", IR, ExecStart, State, exp); end
    tick();
    n_cmp++; if (State !== 3'd5 || Halted !== 1'b1) begin
      n_err++; $display("FAIL halt_state: got %0d halted %b want 5 1", State, Halted); end
    for (int i = 0; i < 10; i++) begin
      Run = 1'($urandom_range(0, 1));
      MemReady = 1'($urandom_range(0, 1));
      ExecDone = 1'($urandom_range(0, 1));
      tick();
    end
    Run = 1'b0; MemReady = 1'b0; ExecDone = 1'b0;
    n_cmp++; if (State !== 3'd5 || Halted !== 1'b1 || MemRead !== 1'b0) begin
      n_err++; $display("FAIL halt_terminal: got %0d halted %b rd %b want 5 1 0", State, Halted, MemRead); end
    n_cmp++; if (n_es - es0 != 0 || n_inc - inc0 != 0 || n_we - we0 != 0) begin
      n_err++; $display("FAIL halt_counts: got es %0d inc %0d we %0d want 0 0 0", n_es - es0, n_inc - inc0, n_we - we0); end
  endtask

  task automatic test_timeout();
    int k;
    logic [15:0] exp;
    do_reset();
    start_run();
    tick();
    n_cmp++; if (State !== 3'd2) begin n_err++; $display("FAIL to_wait: got %0d want 2", State); end
    k = 0;
    while (Fault !== 1'b1 && k < 400) begin
      tick();
      k++;
    end
    n_cmp++; if (k != 256) begin n_err++; $display("FAIL to_latency: got %0d want 256", k); end
    n_cmp++; if (State !== 3'd6 || MemRead !== 1'b0) begin
      n_err++; $display("FAIL to_state: got %0d rd %b want 6 0", State, MemRead); end
    for (int i = 0; i < 8; i++) begin
      Run = 1'($urandom_range(0, 1));
      MemReady = 1'($urandom_range(0, 1));
      ExecDone = 1'($urandom_range(0, 1));
      tick();
    end
    Run = 1'b0; MemReady = 1'b0; ExecDone = 1'b0;
    n_cmp++; if (State !== 3'd6 || Fault !== 1'b1) begin
      n_err++; $display("FAIL to_terminal: got %0d fault %b want 6 1", State, Fault); end
    // Ready on the last permitted WAIT cycle must still be accepted.
    do_reset();
    start_run();
    tick();
    repeat (255) tick();
    n_cmp++; if (State !== 3'd2) begin n_err++; $display("FAIL to_edge_wait: got %0d want 2", State); end
    MemReady = 1'b1;
    MemData  = 16'h5A5A;
    exp_q.push_back(16'h5A5A);
    tick();
    MemReady = 1'b0;
    exp = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hxxxx;
    n_cmp++; if (State !== 3'd3 || Fault !== 1'b0 || ExecStart !== 1'b1) begin
      n_err++; $display("FAIL to_edge_decode: got %0d fault %b es %b want 3 0 1", State, Fault, ExecStart); end
    n_cmp++; if (IR !== exp) begin n_err++; $display("FAIL to_edge_ir: got %0h want %0h", IR, exp); end
  endtask

  task automatic test_run_drop();
    int inc0;
    logic [15:0] exp;
    do_reset();
    inc0 = n_inc;
    start_run();
    feed_mem(16'h0042, 2);
    exp = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hxxxx;
    n_cmp++; if (IR !== exp) begin n_err++; $display("FAIL rd_ir: got %0h want %0h", IR, exp); end
    tick();
    Run = 1'b0;
    MemReady = 1'b1;
    MemData  = 16'hBEEF;
    tick();
    MemReady = 1'b0;
    n_cmp++; if (State !== 3'd4 || IR !== exp) begin
      n_err++; $display("FAIL rd_exec_hold: got state %0d ir %0h want 4 %0h", State, IR, exp); end
    ExecDone = 1'b1;
    tick();
    ExecDone = 1'b0;
    n_cmp++; if (State !== 3'd0 || PcIncrement !== 1'b1) begin
      n_err++; $display("FAIL rd_exit: got state %0d inc %b want 0 1", State, PcIncrement); end
    repeat (3) tick();
    n_cmp++; if (State !== 3'd0 || n_inc - inc0 != 1) begin
      n_err++; $display("FAIL rd_idle: got state %0d incs %0d want 0 1", State, n_inc - inc0); end
  endtask

  task automatic test_reset_exec();
    int inc0, we0;
    logic [15:0] exp;
    do_reset();
    start_run();
    feed_mem(16'h0777, 0);
    exp = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hxxxx;
    n_cmp++; if (IR !== exp) begin n_err++; $display("FAIL re_ir: got %0h want %0h", IR, exp); end
    tick();
    inc0 = n_inc; we0 = n_we;
    ExecDone = 1'b1;
    BranchTaken = 1'b1;
    BranchTarget = 16'h1111;
    Run = 1'b0;
    #1 Reset = 1'b0;
    #1;
    n_cmp++; if (State !== 3'd0 || IR !== 16'h0000 || PcLoadValue !== 16'h0000) begin
      n_err++; $display("FAIL re_async: got state %0d ir %0h pcl %0h want 0 0 0", State, IR, PcLoadValue); end
    tick();
    ExecDone = 1'b0;
    BranchTaken = 1'b0;
    Reset = 1'b1;
    repeat (2) tick();
    n_cmp++; if (n_inc - inc0 != 0 || n_we - we0 != 0 || State !== 3'd0) begin
      n_err++; $display("FAIL re_no_pulse: got inc %0d we %0d state %0d want 0 0 0", n_inc - inc0, n_we - we0, State); end
  endtask

  task automatic test_back_to_back();
    int es0, inc0, we0, exp_inc, exp_we;
    logic [15:0] data, tgt, exp;
    logic taken;
    do_reset();
    es0 = n_es; inc0 = n_inc; we0 = n_we;
    exp_inc = 0; exp_we = 0;
    start_run();
    for (int i = 0; i < 10; i++) begin
      data  = 16'($urandom_range(0, 16'hEFFF));
      tgt   = 16'($urandom_range(0, 16'hFFFF));
      taken = 1'($urandom_range(0, 1));
      feed_mem(data, $urandom_range(0, 5));
      exp = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hxxxx;
      n_cmp++; if (IR !== exp || ExecStart !== 1'b1) begin
        n_err++; $display("FAIL b2b_ir[%0d]: got %0h es %b want %0h 1", i, IR, ExecStart, exp); end
      finish_exec($urandom_range(0, 3), taken, tgt);
      if (taken) exp_we++; else exp_inc++;
      n_cmp++; if (State !== 3'd1 || PcWriteEnable !== taken || PcIncrement !== !taken) begin
        n_err++; $display("FAIL b2b_pulse[%0d]: got state %0d we %b inc %b want 1 %b %b", i, State, PcWriteEnable, PcIncrement, taken, !taken); end
      if (taken) begin
        exp = (pcl_q.size() > 0) ? pcl_q.pop_front() : 16'hxxxx;
        n_cmp++; if (PcLoadValue !== exp) begin
          n_err++; $display("FAIL b2b_target[%0d]: got %0h want %0h", i, PcLoadValue, exp); end
      end
    end
    Run = 1'b0;
    tick();
    n_cmp++; if (n_es - es0 != 10 || n_inc - inc0 != exp_inc || n_we - we0 != exp_we) begin
      n_err++; $display("FAIL b2b_counts: got es %0d inc %0d we %0d want 10 %0d %0d", n_es - es0, n_inc - inc0, n_we - we0, exp_inc, exp_we); end
    n_cmp++; if (n_both != 0 || exp_q.size() != 0 || pcl_q.size() != 0) begin
      n_err++; $display("FAIL b2b_exclusive: got both %0d leftovers %0d %0d want 0 0 0", n_both, exp_q.size(), pcl_q.size()); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    @(negedge Clock);
    test_reset();
    test_no_branch();
    test_branch();
    test_halt();
    test_timeout();
    test_run_drop();
    test_reset_exec();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #1_000_000;
    n_cmp++;
    n_err++;
    $display("FAIL watchdog: got time limit reached want scenarios complete");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
